// File: rtl/opsum_writeback_pkg.sv
// Shared tiling definitions: writeback FSM states, word size and the tile
// geometry record, which the tiling loader also uses.
package tiling_pkg;
    localparam int WORD_BYTES = 4;
    localparam int GEOM_DIM_W = 8;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} wb_state_e;

    // e rows x f cols x pt channels tile, placed at (row0, ch0) inside an
    // output of out_width columns and out_ch channels (HWC layout).
    typedef struct packed {
        logic [GEOM_DIM_W-1:0] e;
        logic [GEOM_DIM_W-1:0] f;
        logic [GEOM_DIM_W-1:0] pt;
        logic [GEOM_DIM_W-1:0] out_width;
        logic [GEOM_DIM_W-1:0] out_ch;
        logic [GEOM_DIM_W-1:0] row0;
        logic [GEOM_DIM_W-1:0] ch0;
    } tile_geom_t;
endpackage

// File: rtl/opsum_writeback_if.sv
// Command/status, GLB read and DRAM write signals of the opsum writeback DMA.
//   master: controller + memories (drives command and glb_r_data)
//   slave : the writeback engine
interface opsum_writeback_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 8,
    parameter int DIM_WIDTH  = 8
);
    logic                    start;
    logic                    relu_en;
    logic [DIM_WIDTH-1:0]    tile_rows;
    logic [DIM_WIDTH-1:0]    tile_cols;
    logic [DIM_WIDTH-1:0]    tile_ch;
    logic [DIM_WIDTH-1:0]    out_width;
    logic [DIM_WIDTH-1:0]    out_ch;
    logic [DIM_WIDTH-1:0]    row0;
    logic [DIM_WIDTH-1:0]    ch0;
    logic [ADDR_WIDTH-1:0]   glb_src_addr;
    logic [ADDR_WIDTH-1:0]   dram_opsum_base_addr;
    logic [3:0]              glb_re;
    logic [ADDR_WIDTH-1:0]   glb_r_addr;
    logic [DATA_WIDTH*4-1:0] glb_r_data;
    logic                    dram_we;
    logic [ADDR_WIDTH-1:0]   dram_addr;
    logic [DATA_WIDTH*4-1:0] dram_w_data;
    logic                    busy;
    logic                    finish;

    modport master (
        output start, relu_en, tile_rows, tile_cols, tile_ch, out_width, out_ch,
               row0, ch0, glb_src_addr, dram_opsum_base_addr, glb_r_data,
        input  glb_re, glb_r_addr, dram_we, dram_addr, dram_w_data, busy, finish
    );
    modport slave (
        input  start, relu_en, tile_rows, tile_cols, tile_ch, out_width, out_ch,
               row0, ch0, glb_src_addr, dram_opsum_base_addr, glb_r_data,
        output glb_re, glb_r_addr, dram_we, dram_addr, dram_w_data, busy, finish
    );
endinterface

// File: rtl/opsum_writeback_addr_gen.sv
// wb_addr_gen: h/w/c nested counter (c innermost) tracking the GLB read
// issued this cycle, plus the matching DRAM byte address, registered so it
// lines up with the read data one cycle later.
//   clk, rst  : clock, synchronous active-low reset
//   i_clr     : zero the counters (new tile)
//   i_adv     : a read is issued this cycle; step counters
//   i_geom    : latched tile geometry
//   i_base    : latched DRAM base address
//   o_last    : current counters are the tile's final word
//   o_we      : write strobe (delayed i_adv)
//   o_addr    : DRAM byte address for o_we, 0 otherwise
module wb_addr_gen
    import tiling_pkg::*;
#(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_clr,
    input  logic                  i_adv,
    input  tile_geom_t            i_geom,
    input  logic [ADDR_WIDTH-1:0] i_base,
    output logic                  o_last,
    output logic                  o_we,
    output logic [ADDR_WIDTH-1:0] o_addr
);
    localparam logic [GEOM_DIM_W-1:0] ONE = 1;

    logic [GEOM_DIM_W-1:0] r_h, r_w, r_c;
    logic                  r_we;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  w_c_wrap, w_w_wrap, w_h_wrap;
    logic [ADDR_WIDTH-1:0] w_row, w_pix, w_idx, w_addr;

    assign w_c_wrap = (r_c == i_geom.pt - ONE);
    assign w_w_wrap = (r_w == i_geom.f - ONE);
    assign w_h_wrap = (r_h == i_geom.e - ONE);
    assign o_last   = w_c_wrap && w_w_wrap && w_h_wrap;

    // Everything widened to the address width first; wraps modulo 2^ADDR_WIDTH.
    always_comb begin
        w_row  = ADDR_WIDTH'(i_geom.row0) + ADDR_WIDTH'(r_h);
        w_pix  = w_row * ADDR_WIDTH'(i_geom.out_width) + ADDR_WIDTH'(r_w);
        w_idx  = w_pix * ADDR_WIDTH'(i_geom.out_ch) + ADDR_WIDTH'(i_geom.ch0)
               + ADDR_WIDTH'(r_c);
        w_addr = i_base + w_idx * ADDR_WIDTH'(WORD_BYTES);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_h    <= '0;
            r_w    <= '0;
            r_c    <= '0;
            r_we   <= 1'b0;
            r_addr <= '0;
        end else begin
            r_we   <= i_adv;
            r_addr <= i_adv ? w_addr : '0;
            if (i_clr) begin
                r_h <= '0;
                r_w <= '0;
                r_c <= '0;
            end else if (i_adv) begin
                if (!w_c_wrap) begin
                    r_c <= r_c + ONE;
                end else begin
                    r_c <= '0;
                    if (!w_w_wrap) begin
                        r_w <= r_w + ONE;
                    end else begin
                        r_w <= '0;
                        r_h <= r_h + ONE;
                    end
                end
            end
        end
    end

    assign o_we   = r_we;
    assign o_addr = r_addr;
endmodule

// File: rtl/opsum_writeback.sv
// opsum_writeback: streams one finished int32 psum tile from GLB (linear
// reads) to DRAM (HWC-strided writes), one word per cycle, optional ReLU.
//   clk, rst : clock, synchronous active-low reset
//   bus      : opsum_writeback_if.slave (command, GLB read, DRAM write,
//              busy/finish status)
module opsum_writeback
    import tiling_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 8,
    parameter int DIM_WIDTH  = 8
) (
    input logic              clk,
    input logic              rst,
    opsum_writeback_if.slave bus
);
    localparam int WORD_W = DATA_WIDTH * 4;
    localparam logic [DIM_WIDTH-1:0] DIM_ZERO = '0;

    wb_state_e             r_state;
    tile_geom_t            r_geom;
    logic [ADDR_WIDTH-1:0] r_base, r_glb_addr;
    logic [3:0]            r_glb_re;
    logic                  r_relu, r_busy, r_finish, r_zero;

    logic                  w_load, w_adv, w_zero_tile, w_last, w_we, w_neg;
    logic [ADDR_WIDTH-1:0] w_dram_addr;

    assign w_load      = (r_state == IDLE) && bus.start;
    assign w_adv       = (r_state == RUN);
    assign w_zero_tile = (bus.tile_rows == DIM_ZERO) || (bus.tile_cols == DIM_ZERO)
                      || (bus.tile_ch == DIM_ZERO);

    wb_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH)) u_addr_gen (
        .clk    (clk),
        .rst    (rst),
        .i_clr  (w_load),
        .i_adv  (w_adv),
        .i_geom (r_geom),
        .i_base (r_base),
        .o_last (w_last),
        .o_we   (w_we),
        .o_addr (w_dram_addr)
    );

    // An empty tile skips RUN/DRAIN; r_zero delays its finish by a cycle so
    // finish still lands two cycles after start with busy high for one.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_geom     <= '0;
            r_base     <= '0;
            r_glb_addr <= '0;
            r_glb_re   <= '0;
            r_relu     <= 1'b0;
            r_busy     <= 1'b0;
            r_finish   <= 1'b0;
            r_zero     <= 1'b0;
        end else begin
            r_finish <= 1'b0;
            case (r_state)
                IDLE: if (bus.start) begin
                    r_geom <= '{e: bus.tile_rows, f: bus.tile_cols, pt: bus.tile_ch,
                                out_width: bus.out_width, out_ch: bus.out_ch,
                                row0: bus.row0, ch0: bus.ch0};
                    r_base <= bus.dram_opsum_base_addr;
                    r_relu <= bus.relu_en;
                    r_busy <= 1'b1;
                    if (w_zero_tile) begin
                        r_state <= DONE;
                        r_zero  <= 1'b1;
                    end else begin
                        r_state    <= RUN;
                        r_glb_re   <= 4'b1111;
                        r_glb_addr <= bus.glb_src_addr;
                    end
                end
                RUN: if (w_last) begin
                    r_state    <= DRAIN;
                    r_glb_re   <= '0;
                    r_glb_addr <= '0;
                end else begin
                    r_glb_addr <= r_glb_addr + ADDR_WIDTH'(WORD_BYTES);
                end
                DRAIN: begin
                    r_state  <= DONE;
                    r_finish <= 1'b1;
                end
                DONE: begin
                    r_state  <= IDLE;
                    r_busy   <= 1'b0;
                    r_finish <= r_zero;
                    r_zero   <= 1'b0;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Read data arrives the cycle after the read, aligned with w_we.
    assign w_neg           = bus.glb_r_data[WORD_W-1];
    assign bus.dram_we     = w_we;
    assign bus.dram_addr   = w_dram_addr;
    assign bus.dram_w_data = (w_we && !(r_relu && w_neg)) ? bus.glb_r_data : '0;
    assign bus.glb_re      = r_glb_re;
    assign bus.glb_r_addr  = r_glb_addr;
    assign bus.busy        = r_busy;
    assign bus.finish      = r_finish;
endmodule
